// File: rtl/adder_result_checker.sv
// Result checker for the registered carry-lookahead adder: delays each accepted vector LATENCY edges
// and compares {dut_cout,dut_sum} with a golden sum. Define CHK_HALT_ON_ERR_EN to end a run on the first mismatch.
module adder_result_checker #(
    parameter int WIDTH   = 4,
    parameter int LATENCY = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vectors,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [WIDTH-1:0] dut_sum,
    input  logic             dut_cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic             first_err_valid,
    output logic [WIDTH-1:0] first_err_a,
    output logic [WIDTH-1:0] first_err_b,
    output logic             first_err_cin,
    output logic [WIDTH:0]   first_err_got
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0] num_latched;
    logic [CNT_W-1:0] issued;
    logic [CNT_W-1:0] issued_next;

    logic [LATENCY-1:0] pipe_valid;
    logic [LATENCY-1:0] pipe_cin;
    logic [WIDTH-1:0]   pipe_a   [LATENCY];
    logic [WIDTH-1:0]   pipe_b   [LATENCY];
    logic [WIDTH:0]     pipe_exp [LATENCY];

    logic           start_run;
    logic           accept;
    logic           out_valid;
    logic           out_mismatch;
    logic           first_mismatch;
    logic           halt;
    logic [WIDTH:0] golden;
    logic [WIDTH:0] observed;

    assign start_run      = start && ((state == IDLE) || (state == DONE));
    assign accept         = vec_valid && vec_ready;
    assign issued_next    = issued + CNT_ONE;
    assign golden         = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign observed       = {dut_cout, dut_sum};
    assign out_valid      = pipe_valid[LATENCY-1];
    assign out_mismatch   = out_valid && (observed != pipe_exp[LATENCY-1]);
    assign first_mismatch = out_mismatch && !first_err_valid;

`ifdef CHK_HALT_ON_ERR_EN
    assign halt = first_mismatch;
`else
    assign halt = 1'b0;
`endif

    assign vec_ready = (state == RUN);
    assign busy      = (state == RUN) || (state == DRAIN);
    assign done      = (state == DONE);
    assign pass      = (state == DONE) && (err_count == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // DRAIN waits until every in-flight entry has been compared; a halt discards them instead.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = (num_vectors == '0) ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (accept && (issued_next == num_latched)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (pipe_valid == '0) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (halt) begin
            state_next = DONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_valid <= '0;
            pipe_cin   <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_a[i]   <= '0;
                pipe_b[i]   <= '0;
                pipe_exp[i] <= '0;
            end
        end else begin
            pipe_valid[0] <= accept && !halt;
            pipe_cin[0]   <= cin;
            pipe_a[0]     <= a;
            pipe_b[0]     <= b;
            pipe_exp[0]   <= golden;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1] && !halt;
                pipe_cin[i]   <= pipe_cin[i-1];
                pipe_a[i]     <= pipe_a[i-1];
                pipe_b[i]     <= pipe_b[i-1];
                pipe_exp[i]   <= pipe_exp[i-1];
            end
        end
    end

    // Run bookkeeping; only the first mismatch of a run is captured.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            num_latched     <= '0;
            issued          <= '0;
            vec_count       <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_a     <= '0;
            first_err_b     <= '0;
            first_err_cin   <= 1'b0;
            first_err_got   <= '0;
        end else if (start_run) begin
            num_latched     <= num_vectors;
            issued          <= '0;
            vec_count       <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_a     <= '0;
            first_err_b     <= '0;
            first_err_cin   <= 1'b0;
            first_err_got   <= '0;
        end else begin
            if (accept) begin
                issued <= issued_next;
            end
            if (out_valid) begin
                vec_count <= vec_count + CNT_ONE;
            end
            if (out_mismatch && (err_count != '1)) begin
                err_count <= err_count + CNT_ONE;
            end
            if (first_mismatch) begin
                first_err_valid <= 1'b1;
                first_err_a     <= pipe_a[LATENCY-1];
                first_err_b     <= pipe_b[LATENCY-1];
                first_err_cin   <= pipe_cin[LATENCY-1];
                first_err_got   <= observed;
            end
        end
    end

endmodule

// File: tb/tb_adder_result_checker.sv
// Bench for adder_result_checker: drives a registered adder model with optional fault injection
// and predicts counts, first-error capture and done timing from the list of accepted vectors.
module tb_adder_result_checker;

    localparam int WIDTH   = 4;
    localparam int LATENCY = 2;
    localparam int CNT_W   = 16;
`ifdef CHK_HALT_ON_ERR_EN
    localparam bit HALT = 1'b1;
`else
    localparam bit HALT = 1'b0;
`endif
    localparam logic [WIDTH:0] LSB = 1;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
    } vec_t;

    typedef struct {
        vec_t v;
        int   edge_n;
    } acc_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] num_vectors = '0;
    logic             vec_valid = 1'b0;
    logic             vec_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic [WIDTH-1:0] dut_sum;
    logic             dut_cout;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] vec_count;
    logic [CNT_W-1:0] err_count;
    logic             first_err_valid;
    logic [WIDTH-1:0] first_err_a;
    logic [WIDTH-1:0] first_err_b;
    logic             first_err_cin;
    logic [WIDTH:0]   first_err_got;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   fault_en = 1'b0;
    vec_t stim_q[$];
    acc_t acc_q[$];
    int   ready_bad, vc_bad, last_edge, done_edge, halt_edge;
    int   exp_vc, exp_err;
    bit   exp_fev;
    vec_t exp_fv;
    logic [WIDTH:0] exp_got;
    logic [WIDTH:0] adder_pipe [LATENCY];

    adder_result_checker #(.WIDTH(WIDTH), .LATENCY(LATENCY), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .num_vectors(num_vectors),
        .vec_valid(vec_valid), .vec_ready(vec_ready), .a(a), .b(b), .cin(cin),
        .dut_sum(dut_sum), .dut_cout(dut_cout), .busy(busy), .done(done), .pass(pass),
        .vec_count(vec_count), .err_count(err_count), .first_err_valid(first_err_valid),
        .first_err_a(first_err_a), .first_err_b(first_err_b), .first_err_cin(first_err_cin),
        .first_err_got(first_err_got)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [WIDTH:0] golden(vec_t v);
        return {1'b0, v.a} + {1'b0, v.b} + {{WIDTH{1'b0}}, v.cin};
    endfunction

    function automatic bit is_fault(vec_t v);
        return fault_en && (v.a == 4'd3) && (v.b == 4'd4) && !v.cin;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        do begin
            v.a   = WIDTH'($urandom_range(0, 15));
            v.b   = WIDTH'($urandom_range(0, 15));
            v.cin = 1'($urandom_range(0, 1));
        end while ((v.a == 4'd3) && (v.b == 4'd4) && !v.cin);
        return v;
    endfunction

    // Adder under test: LATENCY registers deep, bit 0 flipped on the fault vector when enabled.
    always @(posedge clk) begin
        for (int i = LATENCY - 1; i > 0; i--) adder_pipe[i] <= adder_pipe[i-1];
        adder_pipe[0] <= golden(vec_t'({a, b, cin})) ^ (is_fault(vec_t'({a, b, cin})) ? LSB : '0);
    end
    assign {dut_cout, dut_sum} = adder_pipe[LATENCY-1];

    task automatic model_results();
        exp_vc = 0; exp_err = 0; exp_fev = 1'b0; exp_fv = '0; exp_got = '0;
        foreach (acc_q[i]) begin
            if (halt_edge >= 0 && acc_q[i].edge_n + LATENCY > halt_edge) continue;
            exp_vc++;
            if (is_fault(acc_q[i].v)) begin
                exp_err++;
                if (!exp_fev) begin
                    exp_fev = 1'b1;
                    exp_fv  = acc_q[i].v;
                    exp_got = golden(acc_q[i].v) ^ LSB;
                end
            end
        end
    endtask

    // mode 0: valid every cycle, 1: valid toggles (plus an ignored start pulse), 2: random valid
    task automatic applyStimulus(input int n, input int mode);
        vec_t v;
        bit   model_ready;
        bit   extra_start = 1'b0;
        int   acc = 0;
        int   guard = 0;
        int   evc;
        acc_q.delete();
        ready_bad = 0; vc_bad = 0; last_edge = -1; done_edge = -1; halt_edge = -1;
        start = 1'b1; num_vectors = CNT_W'(n); vec_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (done_edge < 0 && guard < 3000) begin
            model_ready = (acc < n) && !(halt_edge >= 0 && cyc >= halt_edge);
            if (vec_ready !== model_ready) ready_bad++;
            evc = 0;
            foreach (acc_q[i])
                if (acc_q[i].edge_n + LATENCY <= cyc && (halt_edge < 0 || acc_q[i].edge_n + LATENCY <= halt_edge)) evc++;
            if (vec_count !== CNT_W'(evc)) vc_bad++;
            if (done === 1'b1) begin
                done_edge = cyc;
                break;
            end
            case (mode)
                0:       vec_valid = 1'b1;
                1:       vec_valid = ~vec_valid;
                default: vec_valid = 1'($urandom_range(0, 1));
            endcase
            v = (model_ready && stim_q.size() > 0) ? stim_q[0] : rand_vec();
            a = v.a; b = v.b; cin = v.cin;
            if (vec_valid && model_ready) begin
                if (stim_q.size() > 0) void'(stim_q.pop_front());
                acc_q.push_back('{v, cyc + 1});
                acc++;
                last_edge = cyc + 1;
                if (HALT && is_fault(v) && halt_edge < 0) halt_edge = cyc + 1 + LATENCY;
            end
            start = 1'b0; num_vectors = CNT_W'(n);
            if (mode == 1 && acc == 2 && !extra_start) begin
                extra_start = 1'b1; start = 1'b1; num_vectors = CNT_W'(1);
            end
            @(negedge clk);
            guard++;
        end
        vec_valid = 1'b0; start = 1'b0;
        model_results();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++; if ({vec_ready, busy, done, pass, first_err_valid, first_err_cin} !== 6'b0) begin n_fail++; $display("[TB] FAIL reset_flags: got %b want 000000", {vec_ready, busy, done, pass, first_err_valid, first_err_cin}); end
        n_cmp++; if ({vec_count, err_count} !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_counts: got %h want 0", {vec_count, err_count}); end
        n_cmp++; if ({first_err_a, first_err_b, first_err_got} !== 13'h0) begin n_fail++; $display("[TB] FAIL reset_first_err: got %h want 0", {first_err_a, first_err_b, first_err_got}); end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if ({vec_ready, busy, done} !== 3'b0) begin n_fail++; $display("[TB] FAIL idle_after_reset: got %b want 000", {vec_ready, busy, done}); end
    endtask

    task automatic test_exhaustive();
        fault_en = 1'b0; stim_q.delete();
        for (int i = 0; i < 512; i++) stim_q.push_back(vec_t'(9'(i)));
        applyStimulus(512, 0);
        n_cmp++; if (ready_bad !== 0) begin n_fail++; $display("[TB] FAIL exh_ready: got %0d bad cycles want 0", ready_bad); end
        n_cmp++; if (vc_bad !== 0) begin n_fail++; $display("[TB] FAIL exh_vec_timing: got %0d bad cycles want 0", vc_bad); end
        n_cmp++; if (done_edge !== last_edge + LATENCY + 1) begin n_fail++; $display("[TB] FAIL exh_done_edge: got %0d want %0d", done_edge, last_edge + LATENCY + 1); end
        n_cmp++; if (vec_count !== 16'd512) begin n_fail++; $display("[TB] FAIL exh_vec_count: got %0d want 512", vec_count); end
        n_cmp++; if (err_count !== 16'd0) begin n_fail++; $display("[TB] FAIL exh_err_count: got %0d want 0", err_count); end
        n_cmp++; if ({pass, first_err_valid} !== 2'b10) begin n_fail++; $display("[TB] FAIL exh_pass: got %b want 10", {pass, first_err_valid}); end
    endtask

    task automatic test_carry_boundary();
        fault_en = 1'b0; stim_q.delete();
        stim_q.push_back('{4'hF, 4'h0, 1'b1});
        stim_q.push_back('{4'hF, 4'hF, 1'b1});
        applyStimulus(2, 0);
        n_cmp++; if (done_edge !== last_edge + LATENCY + 1) begin n_fail++; $display("[TB] FAIL carry_done_edge: got %0d want %0d", done_edge, last_edge + LATENCY + 1); end
        n_cmp++; if (vec_count !== 16'd2) begin n_fail++; $display("[TB] FAIL carry_vec_count: got %0d want 2", vec_count); end
        n_cmp++; if ({pass, err_count} !== {1'b1, 16'd0}) begin n_fail++; $display("[TB] FAIL carry_pass: got pass=%b err=%0d want pass=1 err=0", pass, err_count); end
    endtask

    task automatic test_injected_fault();
        fault_en = 1'b1; stim_q.delete();
        for (int i = 0; i < 10; i++) stim_q.push_back((i == 4) ? vec_t'({4'd3, 4'd4, 1'b0}) : rand_vec());
        applyStimulus(10, 0);
        n_cmp++; if (ready_bad !== 0) begin n_fail++; $display("[TB] FAIL fault_ready: got %0d bad cycles want 0", ready_bad); end
        n_cmp++; if (vc_bad !== 0) begin n_fail++; $display("[TB] FAIL fault_vec_timing: got %0d bad cycles want 0", vc_bad); end
        n_cmp++; if (done_edge !== ((halt_edge >= 0) ? halt_edge : last_edge + LATENCY + 1)) begin n_fail++; $display("[TB] FAIL fault_done_edge: got %0d want %0d", done_edge, (halt_edge >= 0) ? halt_edge : last_edge + LATENCY + 1); end
        n_cmp++; if (vec_count !== CNT_W'(exp_vc)) begin n_fail++; $display("[TB] FAIL fault_vec_count: got %0d want %0d", vec_count, exp_vc); end
        n_cmp++; if (err_count !== 16'd1) begin n_fail++; $display("[TB] FAIL fault_err_count: got %0d want 1", err_count); end
        n_cmp++; if ({first_err_valid, first_err_a, first_err_b, first_err_cin} !== {1'b1, 4'd3, 4'd4, 1'b0}) begin n_fail++; $display("[TB] FAIL fault_first_vec: got v=%b a=%0d b=%0d c=%b want v=1 a=3 b=4 c=0", first_err_valid, first_err_a, first_err_b, first_err_cin); end
        n_cmp++; if (first_err_got !== 5'h06) begin n_fail++; $display("[TB] FAIL fault_first_got: got %h want 06", first_err_got); end
        n_cmp++; if ({done, pass} !== 2'b10) begin n_fail++; $display("[TB] FAIL fault_verdict: got %b want 10", {done, pass}); end
    endtask

    task automatic test_flow_control();
        fault_en = 1'b0; stim_q.delete();
        applyStimulus(7, 1);
        repeat (3) begin
            vec_valid = 1'b1; a = 4'($urandom_range(0, 15));
            @(negedge clk);
        end
        vec_valid = 1'b0;
        n_cmp++; if (ready_bad !== 0) begin n_fail++; $display("[TB] FAIL flow_ready: got %0d bad cycles want 0", ready_bad); end
        n_cmp++; if (vc_bad !== 0) begin n_fail++; $display("[TB] FAIL flow_vec_timing: got %0d bad cycles want 0", vc_bad); end
        n_cmp++; if (vec_count !== 16'd7) begin n_fail++; $display("[TB] FAIL flow_vec_count: got %0d want 7", vec_count); end
        n_cmp++; if ({done, pass, err_count} !== {2'b11, 16'd0}) begin n_fail++; $display("[TB] FAIL flow_verdict: got done=%b pass=%b err=%0d want 1 1 0", done, pass, err_count); end
    endtask

    task automatic test_multi_error();
        fault_en = 1'b1; stim_q.delete();
        for (int i = 0; i < 12; i++) stim_q.push_back((i == 3 || i == 8) ? vec_t'({4'd3, 4'd4, 1'b0}) : rand_vec());
        applyStimulus(12, 2);
        n_cmp++; if ({ready_bad, vc_bad} !== 64'd0) begin n_fail++; $display("[TB] FAIL multi_timing: got ready_bad=%0d vc_bad=%0d want 0 0", ready_bad, vc_bad); end
        n_cmp++; if (vec_count !== CNT_W'(exp_vc)) begin n_fail++; $display("[TB] FAIL multi_vec_count: got %0d want %0d", vec_count, exp_vc); end
        n_cmp++; if (err_count !== CNT_W'(exp_err)) begin n_fail++; $display("[TB] FAIL multi_err_count: got %0d want %0d", err_count, exp_err); end
        n_cmp++; if ({first_err_valid, first_err_a, first_err_b, first_err_cin, first_err_got} !== {exp_fev, exp_fv, exp_got}) begin n_fail++; $display("[TB] FAIL multi_first_err: got %h want %h", {first_err_valid, first_err_a, first_err_b, first_err_cin, first_err_got}, {exp_fev, exp_fv, exp_got}); end
        n_cmp++; if (pass !== 1'b0) begin n_fail++; $display("[TB] FAIL multi_pass: got %b want 0", pass); end
    endtask

    task automatic test_zero_vectors();
        start = 1'b1; num_vectors = '0;
        @(negedge clk);
        start = 1'b0;
        n_cmp++; if ({busy, done} !== 2'b10) begin n_fail++; $display("[TB] FAIL zero_first_edge: got busy/done %b want 10", {busy, done}); end
        @(negedge clk);
        n_cmp++; if ({busy, done, pass} !== 3'b011) begin n_fail++; $display("[TB] FAIL zero_done: got busy/done/pass %b want 011", {busy, done, pass}); end
        n_cmp++; if ({vec_count, err_count, first_err_valid} !== 33'd0) begin n_fail++; $display("[TB] FAIL zero_counts: got vc=%0d err=%0d fev=%b want 0", vec_count, err_count, first_err_valid); end
    endtask

    task automatic test_reset_midrun();
        vec_t v;
        fault_en = 1'b1;
        start = 1'b1; num_vectors = 16'd10; vec_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            v = (i >= 3) ? vec_t'({4'd3, 4'd4, 1'b0}) : rand_vec();
            a = v.a; b = v.b; cin = v.cin; vec_valid = 1'b1;
            @(negedge clk);
        end
        vec_valid = 1'b0;
        n_cmp++; if ({busy, vec_count, err_count} !== {1'b1, 16'd3, 16'd0}) begin n_fail++; $display("[TB] FAIL midrun_before_reset: got busy=%b vc=%0d err=%0d want 1 3 0", busy, vec_count, err_count); end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if ({vec_ready, busy, done, pass, first_err_valid, vec_count, err_count} !== 37'd0) begin n_fail++; $display("[TB] FAIL midrun_reset_values: got %h want 0", {vec_ready, busy, done, pass, first_err_valid, vec_count, err_count}); end
        reset = 1'b0;
        repeat (4) begin
            a = 4'd3; b = 4'd4; cin = 1'b0; vec_valid = 1'b1;
            @(negedge clk);
        end
        vec_valid = 1'b0;
        n_cmp++; if ({done, first_err_valid, vec_count, err_count} !== 34'd0) begin n_fail++; $display("[TB] FAIL midrun_in_flight_dropped: got %h want 0", {done, first_err_valid, vec_count, err_count}); end
        fault_en = 1'b0; stim_q.delete();
        applyStimulus(6, 0);
        n_cmp++; if ({ready_bad, vc_bad} !== 64'd0) begin n_fail++; $display("[TB] FAIL rerun_timing: got ready_bad=%0d vc_bad=%0d want 0 0", ready_bad, vc_bad); end
        n_cmp++; if ({done, pass, vec_count, err_count} !== {2'b11, 16'd6, 16'd0}) begin n_fail++; $display("[TB] FAIL rerun_verdict: got done=%b pass=%b vc=%0d err=%0d want 1 1 6 0", done, pass, vec_count, err_count); end
    endtask

    initial begin
        test_reset();
        test_exhaustive();
        test_carry_boundary();
        test_injected_fault();
        test_flow_control();
        test_multi_error();
        test_zero_vectors();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_result_checker.md
# adder_result_checker

Self-checking result stage that sits directly downstream of the registered carry-lookahead adder in the adder-comparison bench. It observes each operand vector as the vector is driven into the adder and delays the vector through a LATENCY-deep pipeline. It compares the adder's registered Sum/Cout against a golden A+B+Cin computed internally, and reports a per-run vector count, a saturating error count, the first failing vector and a pass/fail verdict. A small run-control FSM frames each test run.

## Interface
Parameters:
- WIDTH, 4, operand/sum width of the adder under test.
- LATENCY, 2, clock edges from operand capture by the adder to valid registered Sum/Cout.
- CNT_W, 16, width of num_vectors, vec_count, err_count.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  single-cycle pulse; starts a run from IDLE or DONE.
- num_vectors  input  CNT_W  vectors to accept in this run; sampled on start.
- vec_valid  input  1  a/b/cin hold a vector this cycle.
- vec_ready  output  1  high only in RUN; a vector is accepted when vec_valid && vec_ready.
- a, b  input  WIDTH  operands, identical to those driven on the adder's A/B.
- cin  input  1  carry-in, identical to the adder's Cin.
- dut_sum  input  WIDTH  adder registered Sum.
- dut_cout  input  1  adder registered Cout.
- busy  output  1  state is RUN or DRAIN.
- done  output  1  state is DONE.
- pass  output  1  valid when done; 1 iff err_count == 0.
- vec_count  output  CNT_W  vectors checked this run.
- err_count  output  CNT_W  mismatches this run; saturates at all-ones.
- first_err_valid  output  1  a mismatch has been captured this run.
- first_err_a, first_err_b  output  WIDTH  operands of the first mismatch.
- first_err_cin  output  1  cin of the first mismatch.
- first_err_got  output  WIDTH+1  {dut_cout,dut_sum} observed at the first mismatch.

## Operation
- The FSM has four states: IDLE, RUN, DRAIN, DONE. Reset enters IDLE.
- IDLE/DONE + start:
  - Clear vec_count, err_count, first_err_* and the issued counter.
  - Latch num_vectors.
  - Go to RUN, or go to DRAIN if num_vectors == 0.
- RUN: each accepted vector is pushed into the delay pipeline and increments the issued counter. When the issued counter reaches num_vectors after an accept, go to DRAIN at that same edge.
- DRAIN: vec_ready is 0 and vec_valid is ignored. When no valid entry remains in the pipeline, go to DONE.
- DONE: outputs hold until start or reset.
- A start pulse in RUN or DRAIN is ignored.
- Vectors offered while vec_ready = 0 are never checked and never counted.
- Golden result: expected = {1'b0,a} + {1'b0,b} + cin, computed at WIDTH+1 bits with no truncation. It is carried in the pipeline alongside a, b, cin and a valid bit.
- Check: when the pipeline's output entry is valid, compare {dut_cout,dut_sum} against expected.
  - vec_count increments on every valid output entry.
  - err_count increments on a mismatch, saturating at all-ones.
  - On the first mismatch only, first_err_* load and first_err_valid sets.
- Reset mid-run: all pipeline valid bits, counters and flags clear immediately; no in-flight vector is ever checked.

## Timing
- Reset values: vec_ready 0, busy 0, done 0, pass 0, vec_count 0, err_count 0, first_err_valid 0, all first_err_* fields 0.
- Alignment: a vector accepted at edge E0 (the adder captures it at the same edge) is compared against dut_sum/dut_cout sampled at edge E0+LATENCY. vec_count and err_count reflect that vector immediately after that edge.
- Back-to-back vectors, one per cycle, are supported with no bubbles.
- Last vector accepted at edge E: state is DRAIN after E and done = 1 after edge E+LATENCY+1.
- num_vectors == 0: done = 1 and pass = 1 two edges after start.
- pass is combinational from state == DONE && err_count == 0.

## Configuration
- CHK_HALT_ON_ERR_EN defined: on the edge that records the first mismatch, the FSM goes straight to DONE. Remaining in-flight entries are discarded unchecked, vec_ready drops, and pass = 0.
- CHK_HALT_ON_ERR_EN undefined: every accepted vector is checked regardless of errors.

## Test plan
- Exhaustive run: num_vectors = 512, all a/b/cin combinations back-to-back against a correct adder -> done, pass = 1, vec_count = 512, err_count = 0, first_err_valid = 0.
- Carry boundary: a = 4'hF, b = 4'h0, cin = 1 and a = 4'hF, b = 4'hF, cin = 1 -> expected 5'h10 and 5'h1F, no errors.
- Injected fault: force dut_sum bit 0 inverted only for the vector a = 3, b = 4, cin = 0, in a run of 10 vectors -> err_count = 1, first_err_a = 3, first_err_b = 4, first_err_got = 5'h06, pass = 0. With CHK_HALT_ON_ERR_EN, done is asserted at that check edge and vec_count stops there.
- Flow control: vec_valid toggles every cycle; vectors offered during DRAIN/IDLE -> only accepted vectors counted, vec_count = num_vectors.
- Reset mid-run after 5 vectors with 2 in flight -> all outputs return to reset values next cycle, and a new start runs cleanly.
- num_vectors = 0 start -> done = 1 and pass = 1 after 2 edges, vec_count = 0.
